// File: rtl/loader_pkg.sv
// Shared types and defaults for the serial instruction-memory loader.
package loader_pkg;

   localparam int unsigned DEPTH = 1024;
   localparam int unsigned LEN_W = 11;
   // First received byte of a word lands in the most significant lane.
   localparam bit MSB_FIRST = 1'b1;

   typedef enum logic [2:0] {
      StIdle,
      StRecv,
      StWrite,
      StCksum,
      StDone,
      StErr
   } state_e;

endpackage

// File: rtl/im_loader_asm.sv
// Byte-to-word shift assembler with the 2-bit byte-in-word counter.
module im_loader_asm
   import loader_pkg::*;
(
   input  logic        clk_i,
   input  logic        clr_i,
   input  logic        clear_i,
   input  logic        shift_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_next_o,
   output logic        last_o
);

   logic [31:0] word_q;
   logic [1:0]  cnt_q;

   always_comb begin
      if (MSB_FIRST) begin
         word_next_o = {word_q[23:0], byte_i};
      end else begin
         word_next_o = {byte_i, word_q[31:8]};
      end
      last_o = (cnt_q == 2'd3);
   end

   always_ff @(posedge clk_i) begin
      if (clr_i || clear_i) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else if (shift_i) begin
         word_q <= word_next_o;
         cnt_q  <= cnt_q + 2'd1;
      end
   end

endmodule

// File: rtl/im_loader.sv
// Loads a byte stream into instruction memory word by word, then verifies a
// trailing checksum byte while keeping the CPU held in reset.
module im_loader #(
   parameter int unsigned DEPTH = loader_pkg::DEPTH,
   parameter int unsigned LEN_W = loader_pkg::LEN_W
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             byte_valid,
   input  logic [7:0]       byte_data,
   output logic             byte_ready,
   output logic             im_we,
   output logic [31:0]      im_addr,
   output logic [31:0]      im_wdata,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             cpu_hold
);
   import loader_pkg::*;

   localparam logic [LEN_W-1:0] DepthL = LEN_W'(DEPTH);

   state_e           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] idx_q, idx_d;
   logic [7:0]       sum_q, sum_d, sum_acc;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             xfer, asm_clear, asm_shift, asm_last;
   logic [31:0]      asm_word;

   im_loader_asm u_asm (
      .clk_i       (clk),
      .clr_i       (clr),
      .clear_i     (asm_clear),
      .shift_i     (asm_shift),
      .byte_i      (byte_data),
      .word_next_o (asm_word),
      .last_o      (asm_last)
   );

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      idx_d     = idx_q;
      sum_d     = sum_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      asm_clear = 1'b0;
      asm_shift = 1'b0;

      byte_ready = (state_q == StRecv) || (state_q == StCksum);
      xfer       = byte_valid && byte_ready;
      sum_acc    = sum_q + byte_data;

      case (state_q)
         StIdle, StDone, StErr: begin
            if (start) begin
               if (len == '0) begin
                  state_d = StDone;
               end else if (len > DepthL) begin
                  state_d = StErr;
               end else begin
                  len_d     = len;
                  idx_d     = '0;
                  sum_d     = '0;
                  asm_clear = 1'b1;
                  state_d   = StRecv;
               end
            end
         end
         StRecv: begin
            if (xfer) begin
               sum_d     = sum_acc;
               asm_shift = 1'b1;
               // Capture address/data here so WRITE follows the 4th byte directly.
               if (asm_last) begin
                  addr_d  = {{(30 - LEN_W){1'b0}}, idx_q, 2'b00};
                  wdata_d = asm_word;
                  state_d = StWrite;
               end
            end
         end
         StWrite: begin
            idx_d   = idx_q + 1'b1;
            state_d = (idx_q == len_q - 1'b1) ? StCksum : StRecv;
         end
         StCksum: begin
            if (xfer) begin
               sum_d   = sum_acc;
               state_d = (sum_acc == 8'h00) ? StDone : StErr;
            end
         end
         default: state_d = StIdle;
      endcase

      im_we    = (state_q == StWrite);
      im_addr  = addr_q;
      im_wdata = wdata_q;
      busy     = (state_q == StRecv) || (state_q == StWrite) || (state_q == StCksum);
      done     = (state_q == StDone);
      err      = (state_q == StErr);
      cpu_hold = busy || (state_q == StErr);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= StIdle;
         len_q   <= '0;
         idx_q   <= '0;
         sum_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         sum_q   <= sum_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: expected writes are queued as bytes are sent.
module tb_im_loader;

   localparam int DEPTH = 1024;
   localparam int LEN_W = 11;

   logic             clk = 1'b0;
   logic             clr, start, byte_valid;
   logic [LEN_W-1:0] len;
   logic [7:0]       byte_data;
   logic             byte_ready, im_we, busy, done, err, cpu_hold;
   logic [31:0]      im_addr, im_wdata;

   im_loader #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
      .clk        (clk),
      .clr        (clr),
      .start      (start),
      .len        (len),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .im_we      (im_we),
      .im_addr    (im_addr),
      .im_wdata   (im_wdata),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .cpu_hold   (cpu_hold)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   logic [31:0] wbuf[$];
   logic [7:0]  tb_sum;
   int          n_checks = 0;
   int          n_errs   = 0;
   int          n_writes = 0;
   int          w0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   wr_t e;
   always @(negedge clk) begin
      if (im_we === 1'b1) begin
         n_writes++;
         if (exp_q.size() == 0) begin
            check("unexpected_we", im_we, 0);
         end else begin
            e = exp_q.pop_front();
            check("we_addr", im_addr, e.addr);
            check("we_data", im_wdata, e.data);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      while (byte_ready !== 1'b1 && t < 20) begin
         tick();
         t++;
      end
      if (byte_ready !== 1'b1) check("byte_ready_timeout", byte_ready, 1);
      else begin
         tick();
         tb_sum += b;
      end
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
   endtask

   task automatic send_word(input logic [31:0] w, input logic [31:0] addr, input bit gap);
      logic [31:0] wv;
      exp_q.push_back({addr, w});
      wv = w;
      for (int i = 0; i < 4; i++) begin
         send_byte(wv[31-8*i -: 8]);
         if (i == 3) check("we_latency", im_we, 1);
         if (gap) tick();
      end
   endtask

   task automatic do_start(input int n);
      start = 1'b1;
      len   = LEN_W'(n);
      tick();
      start = 1'b0;
      len   = LEN_W'($urandom);
   endtask

   task automatic fill(input int n);
      wbuf.delete();
      for (int i = 0; i < n; i++) wbuf.push_back($urandom);
   endtask

   // fix_ck=0 sends the byte that zeroes the running sum.
   task automatic load(input int n, input bit gap, input bit fix_ck, input logic [7:0] ck);
      logic [7:0] cb;
      tb_sum = 8'h00;
      do_start(n);
      for (int i = 0; i < n; i++) send_word(wbuf[i], 32'(i * 4), gap);
      cb = fix_ck ? ck : 8'(-tb_sum);
      send_byte(cb);
   endtask

   initial begin
      clr = 1'b1; start = 1'b0; len = '0; byte_valid = 1'b0; byte_data = 8'h5A;
      tick(); tick();
      clr = 1'b0;
      check("rst_byte_ready", byte_ready, 0);
      check("rst_im_we", im_we, 0);
      check("rst_im_addr", im_addr, 0);
      check("rst_im_wdata", im_wdata, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_cpu_hold", cpu_hold, 0);

      // Good single-word load
      wbuf.delete(); wbuf.push_back(32'h20080005);
      load(1, 1'b0, 1'b1, 8'hD3);
      check("ok_done", done, 1);
      check("ok_err", err, 0);
      check("ok_cpu_hold", cpu_hold, 0);
      check("ok_busy", busy, 0);
      check("ok_wdata_hold", im_wdata, 32'h20080005);
      repeat (3) tick();
      check("ok_done_sticky", done, 1);

      // Bad checksum
      load(1, 1'b0, 1'b1, 8'h00);
      check("bad_err", err, 1);
      check("bad_done", done, 0);
      check("bad_cpu_hold", cpu_hold, 1);
      repeat (4) tick();
      check("bad_err_sticky", err, 1);
      check("bad_hold_sticky", cpu_hold, 1);

      // Two words with byte_valid toggling
      w0 = n_writes;
      fill(2);
      load(2, 1'b1, 1'b0, 8'h00);
      check("gap_done", done, 1);
      check("gap_writes", n_writes - w0, 2);

      // Abort mid-word, then reload
      w0 = n_writes;
      do_start(1);
      send_byte(8'hAA);
      send_byte(8'hBB);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_cpu_hold", cpu_hold, 0);
      check("abort_wdata", im_wdata, 0);
      check("abort_no_write", n_writes - w0, 0);
      wbuf.delete(); wbuf.push_back(32'h11223344);
      load(1, 1'b0, 1'b0, 8'h00);
      check("reload_done", done, 1);

      // len=0, then start during RECV
      w0 = n_writes;
      do_start(0);
      check("len0_done", done, 1);
      check("len0_busy", busy, 0);
      tick();
      check("len0_no_write", n_writes - w0, 0);
      tb_sum = 8'h00;
      do_start(1);
      exp_q.push_back({32'h0, 32'hCAFEF00D});
      send_byte(8'hCA);
      start = 1'b1; len = LEN_W'(2);
      tick();
      start = 1'b0;
      check("recv_start_busy", busy, 1);
      send_byte(8'hFE);
      send_byte(8'hF0);
      send_byte(8'h0D);
      check("recv_start_we", im_we, 1);
      send_byte(8'(-tb_sum));
      check("recv_start_done", done, 1);
      check("recv_start_q", exp_q.size(), 0);

      // Oversized length
      do_start(1100);
      check("big_err", err, 1);
      check("big_busy", busy, 0);

      // clr wins over start
      start = 1'b1; len = LEN_W'(1); clr = 1'b1;
      tick();
      start = 1'b0; clr = 1'b0;
      check("prio_busy", busy, 0);
      check("prio_err", err, 0);

      // Full-depth load
      fill(DEPTH);
      load(DEPTH, 1'b0, 1'b0, 8'h00);
      check("full_done", done, 1);
      check("full_last_addr", im_addr, 32'hFFC);
      check("final_queue", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
